// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the integer register file and RAW scoreboard.
package regfile_scoreboard_pkg;
    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;
    localparam int REG_A0   = 10;
    localparam int REG_SP   = 2;

    typedef logic [4:0] regidx_t;
endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Saturating up/down counter of in-flight writers for one architectural register.
module pend_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;

    // Simultaneous inc and dec cancel; clear beats both.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (inc && !dec && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign count = r_count;
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with same-cycle WB bypass and a per-register RAW scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int              XLEN    = regfile_scoreboard_pkg::XLEN,
    parameter int              PEND_W  = 3,
    parameter logic [XLEN-1:0] SP_INIT = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic            issue_en_rd,
    input  logic [4:0]      issue_rd,
    output logic            src_stall,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [XLEN-1:0] a0,
    output logic [XLEN-1:0] a1,
    output logic [XLEN-1:0] a2,
    output logic [XLEN-1:0] a3,
    output logic [XLEN-1:0] a4,
    output logic [XLEN-1:0] a5,
    output logic [XLEN-1:0] a6,
    output logic [XLEN-1:0] a7
);
    logic [XLEN-1:0]   r_regs [NUM_REGS];
    logic [PEND_W-1:0] w_pend [NUM_REGS];

    regidx_t w_rs1;
    regidx_t w_rs2;
    regidx_t w_rd;
    regidx_t w_wbrd;
    logic    w_wb_wr;
    logic    w_byp1;
    logic    w_byp2;
    logic    w_haz1;
    logic    w_haz2;
    logic    w_full;
    logic    w_issue_fire;

    assign w_rs1   = rs1_addr;
    assign w_rs2   = rs2_addr;
    assign w_rd    = issue_rd;
    assign w_wbrd  = wb_rd;
    assign w_wb_wr = wb_en && (w_wbrd != '0);

    // x0 is never written, so r_regs[0] stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == REG_SP) ? SP_INIT : '0;
            end
        end else if (w_wb_wr) begin
            r_regs[w_wbrd] <= wb_data;
        end
    end

    assign w_byp1 = wb_en && (w_wbrd == w_rs1);
    assign w_byp2 = wb_en && (w_wbrd == w_rs2);

    assign rs1_data = (w_rs1 == '0) ? '0 : (w_byp1 ? wb_data : r_regs[w_rs1]);
    assign rs2_data = (w_rs2 == '0) ? '0 : (w_byp2 ? wb_data : r_regs[w_rs2]);

    // A single outstanding writer retiring now is covered by the bypass.
    assign w_haz1 = rs1_used && (w_rs1 != '0) &&
                    (w_pend[w_rs1] > (w_byp1 ? PEND_W'(1) : PEND_W'(0)));
    assign w_haz2 = rs2_used && (w_rs2 != '0) &&
                    (w_pend[w_rs2] > (w_byp2 ? PEND_W'(1) : PEND_W'(0)));

    assign w_full = issue_valid && issue_en_rd && (w_rd != '0) &&
                    (&w_pend[w_rd]) && !(wb_en && (w_wbrd == w_rd));

    assign src_stall    = !reset && issue_valid && (w_haz1 || w_haz2 || w_full);
    assign w_issue_fire = issue_valid && !src_stall && issue_en_rd && (w_rd != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign w_pend[gi] = '0;
            end else begin : g_cnt
                pend_counter #(
                    .W(PEND_W)
                ) u_pend (
                    .clk  (clk),
                    .reset(reset),
                    .clr  (flush),
                    .inc  (w_issue_fire && (w_rd == regidx_t'(gi))),
                    .dec  (w_wb_wr && (w_wbrd == regidx_t'(gi))),
                    .count(w_pend[gi])
                );
            end
        end
    endgenerate

    assign a0 = r_regs[REG_A0 + 0];
    assign a1 = r_regs[REG_A0 + 1];
    assign a2 = r_regs[REG_A0 + 2];
    assign a3 = r_regs[REG_A0 + 3];
    assign a4 = r_regs[REG_A0 + 4];
    assign a5 = r_regs[REG_A0 + 5];
    assign a6 = r_regs[REG_A0 + 6];
    assign a7 = r_regs[REG_A0 + 7];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_scoreboard;
    localparam logic [63:0] SPI    = 64'h8000_0000;
    localparam int          PMAX   = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, issue_rd = '0, wb_rd = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0;
    logic        issue_valid = 1'b0, issue_en_rd = 1'b0, wb_en = 1'b0, flush = 1'b0;
    logic [63:0] wb_data = '0;
    logic [63:0] rs1_data, rs2_data;
    logic        src_stall;
    logic [63:0] a0, a1, a2, a3, a4, a5, a6, a7;

    logic [63:0] m_regs [32];
    int          m_pend [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(64), .PEND_W(3), .SP_INIT(SPI)) dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_en_rd(issue_en_rd), .issue_rd(issue_rd),
        .src_stall(src_stall),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = (r == 2) ? SPI : 64'h0;
            m_pend[r] = 0;
        end
    endtask

    function automatic logic [63:0] m_read(input logic [4:0] a);
        if (a == 0) return 64'h0;
        if (wb_en && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_src_haz(input logic used, input logic [4:0] a);
        int allowed;
        if (!used || a == 0) return 1'b0;
        allowed = (wb_en && wb_rd == a) ? 1 : 0;
        return m_pend[a] > allowed;
    endfunction

    function automatic logic m_stall();
        logic full;
        if (reset || !issue_valid) return 1'b0;
        full = issue_en_rd && issue_rd != 0 && m_pend[issue_rd] == PMAX &&
               !(wb_en && wb_rd == issue_rd);
        return m_src_haz(rs1_used, rs1_addr) || m_src_haz(rs2_used, rs2_addr) || full;
    endfunction

    function automatic logic [63:0] a_out(input int i);
        case (i)
            0: return a0; 1: return a1; 2: return a2; 3: return a3;
            4: return a4; 5: return a5; 6: return a6; default: return a7;
        endcase
    endfunction

    // One clock: check combinational outputs, advance the model, cross the edge.
    task automatic step(input string name);
        logic st, fire, wbw;
        #1;
        st = m_stall();
        check("rs1_data", rs1_data, m_read(rs1_addr));
        check("rs2_data", rs2_data, m_read(rs2_addr));
        check("src_stall", {63'h0, src_stall}, {63'h0, st});
        if (!reset) begin
            for (int i = 0; i < 8; i++) check("a_reg", a_out(i), m_regs[10 + i]);
        end
        if (name != "")
            $display("[TB] %s rs1=%h rs2=%h stall=%0b", name, rs1_data, rs2_data, src_stall);
        fire = issue_valid && !st && issue_en_rd && issue_rd != 0;
        wbw  = wb_en && wb_rd != 0;
        if (reset) begin
            m_reset();
        end else begin
            if (wbw) m_regs[wb_rd] = wb_data;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_pend[r] = 0;
            end else begin
                if (fire && !(wbw && wb_rd == issue_rd)) m_pend[issue_rd]++;
                if (wbw && !(fire && wb_rd == issue_rd) && m_pend[wb_rd] > 0) m_pend[wb_rd]--;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
        issue_valid = 0; issue_en_rd = 0; issue_rd = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle(); issue_valid = 1; issue_en_rd = 1; issue_rd = rd;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [63:0] d);
        wb_en = 1; wb_rd = rd; wb_data = d;
    endtask

    initial begin
        m_reset();
        step("reset0");
        step("reset1");

        // Reset state
        idle(); rs1_addr = 2; rs2_addr = 5; rs1_used = 1; rs2_used = 1; issue_valid = 1;
        #1;
        check("sp_init", rs1_data, SPI);
        check("x5_zero", rs2_data, 64'h0);
        check("rst_stall", {63'h0, src_stall}, 64'h0);
        check("rst_a0", a0, 64'h0);
        step("reset_read");

        // RAW on x5 resolved by the bypass
        issue(5); step("issue_x5");
        idle(); issue_valid = 1; rs1_addr = 5; rs1_used = 1;
        #1; check("raw_stall", {63'h0, src_stall}, 64'h1);
        step("raw_wait0"); step("raw_wait1");
        wb(5, 64'hDEAD);
        #1;
        check("raw_byp_stall", {63'h0, src_stall}, 64'h0);
        check("raw_byp_data", rs1_data, 64'hDEAD);
        step("raw_retire");

        // x0 write and issue ignored
        issue(0); rs1_addr = 0; rs1_used = 1; wb(0, 64'h1234);
        #1;
        check("x0_data", rs1_data, 64'h0);
        check("x0_stall", {63'h0, src_stall}, 64'h0);
        step("x0_write");
        idle(); issue_valid = 1; rs1_addr = 0; rs1_used = 1;
        #1; check("x0_after", rs1_data, 64'h0);
        step("x0_read");

        // Two writers to x7
        issue(7); step("issue_x7a");
        issue(7); step("issue_x7b");
        idle(); issue_valid = 1; rs2_addr = 7; rs2_used = 1; wb(7, 64'h111);
        #1; check("x7_first_wb", {63'h0, src_stall}, 64'h1);
        step("x7_wb1");
        wb(7, 64'h222);
        #1;
        check("x7_second_wb", {63'h0, src_stall}, 64'h0);
        check("x7_byp", rs2_data, 64'h222);
        step("x7_wb2");

        // Saturate pend[3]
        for (int i = 0; i < PMAX; i++) begin issue(3); step("fill_x3"); end
        issue(3);
        #1; check("x3_full", {63'h0, src_stall}, 64'h1);
        step("x3_full");
        issue(3); wb(3, 64'h33);
        #1; check("x3_full_wb", {63'h0, src_stall}, 64'h0);
        step("x3_full_wb");
        issue(3);
        #1; check("x3_still_full", {63'h0, src_stall}, 64'h1);
        step("x3_still_full");
        for (int i = 0; i < PMAX; i++) begin idle(); wb(3, 64'h30 + 64'(i)); step("drain_x3"); end

        // Flush with concurrent WB to a0
        issue(4); step("issue_x4");
        issue(5); step("issue_x5b");
        idle(); flush = 1; wb(10, 64'd42); step("flush");
        idle(); issue_valid = 1; rs1_addr = 4; rs1_used = 1;
        #1;
        check("flush_a0", a0, 64'd42);
        check("flush_nostall", {63'h0, src_stall}, 64'h0);
        step("after_flush");

        // Reset mid-stall
        issue(6); step("issue_x6");
        idle(); issue_valid = 1; rs1_addr = 6; rs1_used = 1;
        #1; check("pre_rst_stall", {63'h0, src_stall}, 64'h1);
        reset = 1;
        #1; check("in_rst_stall", {63'h0, src_stall}, 64'h0);
        step("mid_reset");
        reset = 0;
        #1; check("post_rst_stall", {63'h0, src_stall}, 64'h0);
        step("post_reset");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom % 400) == 0;
            rs1_addr    = 5'($urandom_range(0, 12));
            rs2_addr    = 5'($urandom_range(0, 12));
            rs1_used    = 1'($urandom % 2);
            rs2_used    = 1'($urandom % 2);
            issue_valid = ($urandom % 4) != 0;
            issue_en_rd = ($urandom % 3) != 0;
            issue_rd    = 5'($urandom_range(0, 12));
            wb_en       = 1'($urandom % 2);
            wb_rd       = 5'($urandom_range(0, 12));
            wb_data     = {$urandom, $urandom};
            flush       = ($urandom % 50) == 0;
            step("");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
